seg_snake_ring: RTL and testbench
=================================

# seg_snake_ring

Parametrised multi-digit 7-segment "snake" animator. A snake of programmable length runs around the outer perimeter of a row of `DIGITS` seven-segment digits. The step rate is selectable. Direction reversal can be requested by command or triggered pseudo-randomly. The block drives a flat segment bitmap for an external display driver or multiplexer and sits between the top-level pin wrapper and the display outputs.

## Interface
Parameters:
- `DIGITS`, default 4: number of digits; ring length `P = 2*DIGITS+4`.
- `MAX_LEN`, default 6: snake length ceiling; legal range 1..P.
- `INIT_LEN`, default 3: length after reset; legal range 1..MAX_LEN.
- `DIV_W`, default 26: width of the step-rate divider counter.
- `SEED`, default 24'h1A037: LFSR reset value; must be nonzero.

Ports:
- `clk` in 1: single clock; all state on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `speed` in 4: selects divider bit `DIV_W-1-speed`; clamped to bit 0 when `speed > DIV_W-1`.
- `run` in 1: 1 = snake advances on steps; 0 = frozen.
- `rev_req` in 1: one-cycle pulse; requests a reversal.
- `grow` in 1: one-cycle pulse; requests length+1.
- `shrink` in 1: one-cycle pulse; requests length-1.
- `auto_rev` in 1: enables random reversals.
- `segs` out DIGITS*8: bit `d*8+s` is digit d, segment s (0..6 = a..g, 7 = dp).
- `head_pos` out $clog2(P): ring index of the head.
- `len` out $clog2(MAX_LEN+1): current length.
- `dir` out 1: 0 = clockwise (increasing index), 1 = counter-clockwise.
- `step` out 1: high for one cycle when a step edge occurs.

## Operation
- Ring index to segment mapping:
  - i in 0..DIGITS-1: digit i, seg a.
  - i = DIGITS: digit DIGITS-1, seg b.
  - i = DIGITS+1: digit DIGITS-1, seg c.
  - i in DIGITS+2..2*DIGITS+1: digit 2*DIGITS+1-i, seg d.
  - i = 2*DIGITS+2: digit 0, seg e.
  - i = 2*DIGITS+3: digit 0, seg f.
- History `hist[0..MAX_LEN-1]` holds ring indices; `hist[0]` is the head. Entries 0..len-1 are lit.
- `segs`:
  - A segment bit is 1 iff any lit entry maps to it.
  - Seg g is always 0.
  - dp of digit d is 1 iff the head maps into digit d.
- Divider: `cnt` increments every cycle and wraps. Selected bit is registered into p1, then p1 into p2. `step = p1 & ~p2`.
- Pending flags `rev_p`, `grow_p`, `shrink_p` are set by their input pulses.
- Each step with `run=1` performs exactly one action:
  - Reversal when `rev_p`, or when `auto_rev & (lfsr[1:0]==0)`:
    - dir toggles.
    - Entries 0..len-1 are reversed in place, so the old tail becomes the new head. No advance this step.
    - `rev_p` clears. Grow/shrink stay pending.
  - Otherwise, advance:
    - `hist[0] <= head±1 mod P` (+ for dir=0). `hist[k] <= hist[k-1]` for all k.
    - `grow_p` only: len = min(len+1, MAX_LEN).
    - `shrink_p` only: len = max(len-1, 1).
    - Both set: len unchanged.
    - Both flags clear.
- A pulse arriving in the same cycle as an action sets its flag after the clear, so it is kept for the next step.
- `run=0`: steps are ignored; pending flags are kept; the LFSR and divider keep running.
- LFSR: 24-bit, shifts left every cycle; feedback = bit23^bit22^bit21^bit16.
- Reset values:
  - `hist[k] = (P-k) mod P`.
  - len = INIT_LEN, dir = 0, flags 0, cnt 0, p1 = p2 = 0, lfsr = SEED.
  - Hence `head_pos=0`, `step=0`, and `segs` reflect the initial snake during reset.

## Timing
- Selected bit b first rises when cnt = 2^b. p1 follows one cycle later and `step` is high for that cycle. State updates at the next edge, 2^b+2 edges after reset release.
- Steps then recur every 2^(b+1) cycles.
- `segs`, `head_pos`, `len` and `dir` are combinational from registers and change on the edge that ends the step cycle.
- A `speed` change takes effect via the p1/p2 pipeline and may produce one spurious or missed step; this is accepted.
- Asserting `rst` mid-operation clears everything immediately, including pending flags.

## Test plan
- DIGITS=2, INIT_LEN=3, MAX_LEN=6, DIV_W=4, speed=0, run=1:
  - Reset -> `segs=16'h00B1`, `head_pos=0`.
  - First step -> `segs=16'h8121`, `head_pos=1`.
- Same config, 8 clockwise steps -> `segs` returns to `16'h00B1`; `head_pos` wraps 7->0.
- Pulse `rev_req` after reset:
  - Next step -> `dir=1`, `head_pos=6`, `segs=16'h00B1`.
  - Following step -> `head_pos=5`, `segs=16'h00B8`.
- `grow` pulsed before each of 5 steps -> len 4, 5, 6, 6, 6 (saturates). Then `shrink` before each of 7 steps -> len floors at 1.
- `grow` and `shrink` in the same interval -> len unchanged, both flags cleared. `rev_req` together with `grow` -> reversal first, growth applied on the following step.
- `run=0` with a pending `rev_req` over several steps -> no state change. Raise `run` -> reversal on the first step.
- `auto_rev=1` over 1000 steps -> dir toggles match a reference LFSR model.

Source files
------------

// File: rtl/seg_snake_ring.sv
// seg_snake_ring: snake animation running around the perimeter of a row of 7-segment digits
module seg_snake_ring #(
   parameter int          DIGITS   = 4,
   parameter int          MAX_LEN  = 6,
   parameter int          INIT_LEN = 3,
   parameter int          DIV_W    = 26,
   parameter logic [23:0] SEED     = 24'h1A037,
   localparam int         P        = 2*DIGITS+4,
   localparam int         PW       = $clog2(P),
   localparam int         LW       = $clog2(MAX_LEN+1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [3:0]            speed,
   input  logic                  run,
   input  logic                  rev_req,
   input  logic                  grow,
   input  logic                  shrink,
   input  logic                  auto_rev,
   output logic [DIGITS*8-1:0]   segs,
   output logic [PW-1:0]         head_pos,
   output logic [LW-1:0]         len,
   output logic                  dir,
   output logic                  step
);
   localparam int IW = MAX_LEN > 1 ? $clog2(MAX_LEN) : 1;
   localparam int SW = $clog2(DIGITS*8);
   localparam int CW = DIV_W > 1 ? $clog2(DIV_W) : 1;

   function automatic int seg_of(input int i);
      return i < DIGITS        ? i*8 :
             i == DIGITS       ? (DIGITS-1)*8+1 :
             i == DIGITS+1     ? (DIGITS-1)*8+2 :
             i <= 2*DIGITS+1   ? (2*DIGITS+1-i)*8+3 :
             i == 2*DIGITS+2   ? 4 : 5;
   endfunction

   logic [PW-1:0]    hist_q [MAX_LEN];
   logic [PW-1:0]    hist_d [MAX_LEN];
   logic [LW-1:0]    len_q, len_d;
   logic             dir_q, dir_d;
   logic             rev_p_q, rev_p_d;
   logic             grow_p_q, grow_p_d;
   logic             shrink_p_q, shrink_p_d;
   logic             p1_q, p1_d;
   logic             p2_q, p2_d;
   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic [23:0]      lfsr_q, lfsr_d;
   logic [CW-1:0]    sel;
   logic             act, rev_act, adv;
   logic [PW-1:0]    nxt_head;

   always_comb begin
      segs = '0;
      for (int k = 0; k < MAX_LEN; k++)
         if (k < int'(len_q)) segs[SW'(seg_of(int'(hist_q[k])))] = 1'b1;
      segs[SW'(seg_of(int'(hist_q[0])) / 8 * 8 + 7)] = 1'b1;
      head_pos = hist_q[0];
      len = len_q;
      dir = dir_q;
      step = p1_q & ~p2_q;
   end

   always_comb begin
      sel = int'(speed) > DIV_W-1 ? '0 : CW'(DIV_W-1-int'(speed));
      cnt_d = cnt_q + 1'b1;
      lfsr_d = {lfsr_q[22:0], lfsr_q[23] ^ lfsr_q[22] ^ lfsr_q[21] ^ lfsr_q[16]};
      p1_d = cnt_q[sel];
      p2_d = p1_q;
      act = step & run;
      rev_act = act & (rev_p_q | (auto_rev & (lfsr_q[1:0] == 2'b00)));
      adv = act & ~rev_act;
      nxt_head = dir_q ? (hist_q[0] == '0 ? PW'(P-1) : hist_q[0] - 1'b1)
                       : (hist_q[0] == PW'(P-1) ? '0 : hist_q[0] + 1'b1);
      dir_d = dir_q ^ rev_act;
      // new pulses are OR'd in after the clear so a same-cycle pulse survives
      rev_p_d = (rev_p_q & ~rev_act) | rev_req;
      grow_p_d = (grow_p_q & ~adv) | grow;
      shrink_p_d = (shrink_p_q & ~adv) | shrink;
      len_d = (!adv || grow_p_q == shrink_p_q) ? len_q :
              grow_p_q ? (len_q == LW'(MAX_LEN) ? len_q : len_q + 1'b1) :
                         (len_q == LW'(1) ? len_q : len_q - 1'b1);
      hist_d = hist_q;
      if (adv) begin
         hist_d[0] = nxt_head;
         for (int k = 1; k < MAX_LEN; k++) hist_d[k] = hist_q[k-1];
      end
      for (int k = 0; k < MAX_LEN; k++)
         if (rev_act && k < int'(len_q)) hist_d[k] = hist_q[IW'(int'(len_q)-1-k)];
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         for (int k = 0; k < MAX_LEN; k++) hist_q[k] <= PW'((P-k) % P);
         len_q <= LW'(INIT_LEN);
         dir_q <= 1'b0;
         rev_p_q <= 1'b0;
         grow_p_q <= 1'b0;
         shrink_p_q <= 1'b0;
         p1_q <= 1'b0;
         p2_q <= 1'b0;
         cnt_q <= '0;
         lfsr_q <= SEED;
      end else begin
         hist_q <= hist_d;
         len_q <= len_d;
         dir_q <= dir_d;
         rev_p_q <= rev_p_d;
         grow_p_q <= grow_p_d;
         shrink_p_q <= shrink_p_d;
         p1_q <= p1_d;
         p2_q <= p2_d;
         cnt_q <= cnt_d;
         lfsr_q <= lfsr_d;
      end
endmodule

// File: tb/tb_seg_snake_ring.sv
// tb_seg_snake_ring: directed checks of the snake animator in a 2-digit, fast-divider setup
module tb_seg_snake_ring;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  speed = 4'd0;
   logic        run = 1'b1;
   logic        rev_req = 1'b0;
   logic        grow = 1'b0;
   logic        shrink = 1'b0;
   logic        auto_rev = 1'b0;
   logic [15:0] segs;
   logic [2:0]  head_pos;
   logic [2:0]  len;
   logic        dir;
   logic        step;
   int          n_chk = 0;
   int          n_err = 0;
   int          lat;
   logic [23:0] m_lfsr;
   logic [23:0] step_lfsr;
   logic        exp_dir;

   seg_snake_ring #(.DIGITS(2), .MAX_LEN(6), .INIT_LEN(3), .DIV_W(4)) dut (
      .clk(clk), .rst(rst), .speed(speed), .run(run), .rev_req(rev_req),
      .grow(grow), .shrink(shrink), .auto_rev(auto_rev), .segs(segs),
      .head_pos(head_pos), .len(len), .dir(dir), .step(step)
   );

   always #5 clk = ~clk;

   always @(posedge clk or posedge rst)
      if (rst) m_lfsr <= 24'h1A037;
      else m_lfsr <= {m_lfsr[22:0], m_lfsr[23] ^ m_lfsr[22] ^ m_lfsr[21] ^ m_lfsr[16]};

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      run = 1'b1;
      auto_rev = 1'b0;
      {grow, shrink, rev_req} = 3'b000;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic wait_step(output int l);
      l = 0;
      do begin
         @(negedge clk);
         l++;
      end while (!step && l < 64);
      if (!step) chk("step_timeout", 32'd0, 32'd1);
      step_lfsr = m_lfsr;
      @(negedge clk);
   endtask

   task automatic pulse(input logic g, input logic s, input logic r);
      {grow, shrink, rev_req} = {g, s, r};
      @(negedge clk);
      {grow, shrink, rev_req} = 3'b000;
   endtask

   initial begin
      @(negedge clk);
      chk("rst_segs", 32'(segs), 32'h00B1);
      chk("rst_head", 32'(head_pos), 32'd0);
      chk("rst_len", 32'(len), 32'd3);
      chk("rst_dir", 32'(dir), 32'd0);
      chk("rst_step", 32'(step), 32'd0);
      do_reset();
      wait_step(lat);
      chk("first_lat", 32'(lat), 32'd9);
      chk("step1_segs", 32'(segs), 32'h8121);
      chk("step1_head", 32'(head_pos), 32'd1);
      for (int i = 2; i <= 8; i++) begin
         wait_step(lat);
         chk("cw_head", 32'(head_pos), 32'(i % 8));
      end
      chk("step_period", 32'(lat), 32'd15);
      chk("wrap_segs", 32'(segs), 32'h00B1);

      do_reset();
      pulse(1'b0, 1'b0, 1'b1);
      wait_step(lat);
      chk("rev_dir", 32'(dir), 32'd1);
      chk("rev_head", 32'(head_pos), 32'd6);
      chk("rev_segs", 32'(segs), 32'h00B1);
      wait_step(lat);
      chk("ccw_head", 32'(head_pos), 32'd5);
      chk("ccw_segs", 32'(segs), 32'h00B8);

      do_reset();
      for (int i = 0; i < 5; i++) begin
         pulse(1'b1, 1'b0, 1'b0);
         wait_step(lat);
         chk("grow_len", 32'(len), 32'(i < 3 ? 4 + i : 6));
      end
      for (int i = 0; i < 7; i++) begin
         pulse(1'b0, 1'b1, 1'b0);
         wait_step(lat);
         chk("shrink_len", 32'(len), 32'(i < 5 ? 5 - i : 1));
      end

      do_reset();
      pulse(1'b1, 1'b1, 1'b0);
      wait_step(lat);
      chk("both_len", 32'(len), 32'd3);
      wait_step(lat);
      chk("both_clear", 32'(len), 32'd3);
      pulse(1'b1, 1'b0, 1'b1);
      wait_step(lat);
      chk("revgrow_dir", 32'(dir), 32'd1);
      chk("revgrow_len0", 32'(len), 32'd3);
      wait_step(lat);
      chk("revgrow_len1", 32'(len), 32'd4);
      chk("revgrow_dir1", 32'(dir), 32'd1);

      do_reset();
      run = 1'b0;
      pulse(1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) wait_step(lat);
      chk("frozen_head", 32'(head_pos), 32'd0);
      chk("frozen_dir", 32'(dir), 32'd0);
      chk("frozen_segs", 32'(segs), 32'h00B1);
      run = 1'b1;
      wait_step(lat);
      chk("thaw_dir", 32'(dir), 32'd1);
      chk("thaw_head", 32'(head_pos), 32'd6);

      do_reset();
      pulse(1'b0, 1'b0, 1'b1);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_head", 32'(head_pos), 32'd0);
      rst = 1'b0;
      wait_step(lat);
      chk("midrst_dir", 32'(dir), 32'd0);
      chk("midrst_step_head", 32'(head_pos), 32'd1);

      do_reset();
      auto_rev = 1'b1;
      exp_dir = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         wait_step(lat);
         if (step_lfsr[1:0] == 2'b00) exp_dir = ~exp_dir;
         chk("auto_dir", 32'(dir), 32'(exp_dir));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
